// File: rtl/wb_mult_initiator.sv
// Wishbone initiator driving a memory-mapped multiplier: write A, write B, read C low, read C high.
// Optional feature macro WB_MULT_TIMEOUT_EN: abort a stalled access after TIMEOUT_CYCLES and flag rsp_err.
module wb_mult_initiator #(
  parameter logic [16:0] MULT_BASE_ADR  = 17'h00010,
  parameter int unsigned TIMEOUT_CYCLES = 7,
  parameter logic [31:0] ERR_READ_VALUE = 32'hBADFABAC
) (
  input  logic        WB_CLK,
  input  logic        WB_RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_c,
  output logic        rsp_err,
  output logic [16:0] WBs_ADR,
  output logic        WBs_CYC,
  output logic        WBs_STB,
  output logic        WBs_WE,
  output logic        WBs_RD,
  output logic [3:0]  WBs_BYTE_STB,
  output logic [31:0] WBs_WR_DAT,
  input  logic [31:0] WBs_RD_DAT,
  input  logic        WBs_ACK
);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_L, RD_H, GAP, RESP} state_t;

  typedef struct packed {
    logic [16:0] adr;
    logic        we;
    logic [31:0] dat;
  } bus_t;

  state_t      state;
  state_t      after_gap;
  state_t      target;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] c_lo;
  logic [31:0] c_hi;
  bus_t        bus_nxt;
  logic        in_bus;
  logic        done;
  logic        launch;
  logic        finish;

  function automatic bus_t bus_for(input state_t s, input logic [31:0] a, input logic [31:0] b);
    bus_t r;
    r.adr = MULT_BASE_ADR;
    r.we  = 1'b0;
    r.dat = 32'h0;
    case (s)
      WR_A: begin r.adr = MULT_BASE_ADR;          r.we = 1'b1; r.dat = a; end
      WR_B: begin r.adr = MULT_BASE_ADR + 17'd4;  r.we = 1'b1; r.dat = b; end
      RD_L: r.adr = MULT_BASE_ADR + 17'd8;
      RD_H: r.adr = MULT_BASE_ADR + 17'd12;
      default: ;
    endcase
    return r;
  endfunction

  function automatic state_t succ(input state_t s);
    state_t r;
    case (s)
      WR_A:    r = WR_B;
      WR_B:    r = RD_L;
      default: r = RD_H;
    endcase
    return r;
  endfunction

  // The bus phase about to start: WR_A straight from IDLE, otherwise whatever GAP was parked on.
  always_comb begin
    target  = (state == IDLE) ? WR_A : after_gap;
    bus_nxt = bus_for(target, (state == IDLE) ? req_a : op_a, op_b);
  end

  assign in_bus = (state == WR_A) || (state == WR_B) || (state == RD_L) || (state == RD_H);
  assign done   = in_bus && WBs_STB && WBs_ACK;
  assign launch = ((state == IDLE) && req_valid && req_ready) || (state == GAP);
  assign rsp_c  = {c_hi, c_lo};

`ifdef WB_MULT_TIMEOUT_EN
  localparam logic [2:0] TIMEOUT_LIM = 3'(TIMEOUT_CYCLES);

  logic [2:0] cnt;
  logic       err_q;
  logic       expired;

  // An ACK arriving on the cycle the limit is hit still completes the access.
  assign expired = in_bus && WBs_STB && !WBs_ACK && ((cnt + 3'd1) == TIMEOUT_LIM);
  assign finish  = done || expired;
  assign rsp_err = err_q;
`else
  logic [34:0] unused_cfg;

  // Timeout parameters only take effect when the timeout feature is compiled in.
  assign unused_cfg = {ERR_READ_VALUE, 3'(TIMEOUT_CYCLES)};
  assign finish     = done;
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) begin
      state        <= IDLE;
      after_gap    <= WR_A;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      op_a         <= 32'h0;
      op_b         <= 32'h0;
      c_lo         <= 32'h0;
      c_hi         <= 32'h0;
      WBs_ADR      <= 17'h0;
      WBs_CYC      <= 1'b0;
      WBs_STB      <= 1'b0;
      WBs_WE       <= 1'b0;
      WBs_RD       <= 1'b0;
      WBs_BYTE_STB <= 4'h0;
      WBs_WR_DAT   <= 32'h0;
`ifdef WB_MULT_TIMEOUT_EN
      cnt          <= 3'd0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op_a      <= req_a;
            op_b      <= req_b;
            state     <= WR_A;
          end
        end
        WR_A, WR_B, RD_L, RD_H: begin
          if (done) begin
            if (state == RD_L) c_lo <= WBs_RD_DAT;
            if (state == RD_H) begin
              c_hi      <= WBs_RD_DAT;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              after_gap <= succ(state);
              state     <= GAP;
            end
          end
`ifdef WB_MULT_TIMEOUT_EN
          else if (expired) begin
            c_lo      <= ERR_READ_VALUE;
            c_hi      <= ERR_READ_VALUE;
            err_q     <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
`endif
        end
        GAP: state <= after_gap;
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
`ifdef WB_MULT_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase

      // Bus outputs are registered so they line up exactly with the state they belong to.
      if (launch) begin
        WBs_ADR      <= bus_nxt.adr;
        WBs_CYC      <= 1'b1;
        WBs_STB      <= 1'b1;
        WBs_WE       <= bus_nxt.we;
        WBs_RD       <= !bus_nxt.we;
        WBs_BYTE_STB <= 4'hF;
        WBs_WR_DAT   <= bus_nxt.dat;
`ifdef WB_MULT_TIMEOUT_EN
        cnt          <= 3'd0;
`endif
      end else if (finish) begin
        WBs_CYC      <= 1'b0;
        WBs_STB      <= 1'b0;
        WBs_WE       <= 1'b0;
        WBs_RD       <= 1'b0;
        WBs_BYTE_STB <= 4'h0;
        WBs_WR_DAT   <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_wb_mult_initiator.sv
// Scoreboard bench for wb_mult_initiator: directed operand pairs against a Wishbone multiplier model.
`timescale 1ns/1ps
module tb_wb_mult_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = 32'h0;
  logic [31:0] req_b = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_c;
  logic        rsp_err;
  logic [16:0] adr;
  logic        cyc, stb, we, rd;
  logic [3:0]  byte_stb;
  logic [31:0] wr_dat;
  logic [31:0] rd_dat;
  logic        ack;

  wb_mult_initiator dut (
    .WB_CLK(clk), .WB_RST_N(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_err(rsp_err),
    .WBs_ADR(adr), .WBs_CYC(cyc), .WBs_STB(stb), .WBs_WE(we), .WBs_RD(rd),
    .WBs_BYTE_STB(byte_stb), .WBs_WR_DAT(wr_dat), .WBs_RD_DAT(rd_dat), .WBs_ACK(ack)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Multiplier responder: ACK after 'waits' wait states; never ACKs stall_adr.
  int unsigned waits = 0;
  logic [16:0] stall_adr = 17'h1FFFF;
  logic        force_ack = 1'b0;
  int unsigned wcnt = 0;
  logic [31:0] reg_a = 32'h0;
  logic [31:0] reg_b = 32'h0;
  logic [63:0] prod;

  assign prod   = {32'h0, reg_a} * {32'h0, reg_b};
  assign ack    = force_ack || (stb && (adr != stall_adr) && (wcnt == waits));
  assign rd_dat = (adr == 17'h1C) ? prod[63:32] : prod[31:0];

  always @(posedge clk) begin
    if (stb && !ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (stb && ack && we) begin
      if (adr == 17'h10) reg_a <= wr_dat;
      else if (adr == 17'h14) reg_b <= wr_dat;
    end
  end

  typedef struct { logic [16:0] adr; logic we; logic [31:0] dat; } bus_exp_t;
  typedef struct { logic [63:0] c; logic err; } rsp_exp_t;
  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  bus_exp_t be;
  rsp_exp_t re;
  logic     gap_due = 1'b0;

  task automatic exp_bus(input logic [16:0] a, input logic w, input logic [31:0] d);
    bus_exp_t e;
    e.adr = a; e.we = w; e.dat = d;
    bus_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic [63:0] c, input logic err);
    rsp_exp_t e;
    e.c = c; e.err = err;
    rsp_q.push_back(e);
  endtask

  // Monitor: pops expectations whenever a transfer completes or a response is taken.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gap_due) check("gap_stb_low", stb, 1'b0);
      gap_due = 1'b0;
      if (stb && ack) begin
        if (bus_q.size() == 0) check("bus_unexpected", 1'b1, 1'b0);
        else begin
          be = bus_q.pop_front();
          check("bus_adr", adr, be.adr);
          check("bus_we", we, be.we);
          check("bus_rd", rd, !be.we);
          check("bus_wdat", wr_dat, be.dat);
          check("bus_cyc_bsel", {cyc, byte_stb}, 5'h1F);
        end
        gap_due = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 1'b1, 1'b0);
        else begin
          re = rsp_q.pop_front();
          check("rsp_c", rsp_c, re.c);
          check("rsp_err", rsp_err, re.err);
        end
      end
    end
  end

  task automatic handshake(input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_b = b;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("req_ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // exp_cycle numbers the cycles after the handshake edge starting at 1.
  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic [63:0] c,
                         input int exp_cycle, input bit hold);
    int n;
    rsp_ready = !hold;
    exp_rsp(c, 1'b0);
    exp_bus(17'h10, 1'b1, a);
    exp_bus(17'h14, 1'b1, b);
    exp_bus(17'h18, 1'b0, 32'h0);
    exp_bus(17'h1C, 1'b0, 32'h0);
    handshake(a, b);
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("rsp_cycle", n + 1, exp_cycle);
    if (hold) begin
      req_valid = 1'b1; req_a = ~a; req_b = ~b;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("hold_c", rsp_c, c);
        check("hold_valid", rsp_valid, 1'b1);
        check("hold_req_ready", req_ready, 1'b0);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("ready_after_rsp", req_ready, 1'b1);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {req_ready, rsp_valid, rsp_err, cyc, stb, we, rd}, 7'h0);
    check("rst_bus", {adr, byte_stb, wr_dat}, 53'h0);
    check("rst_c", rsp_c, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", req_ready, 1'b1);

    // ACK with no strobe must be ignored.
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray_ack", {stb, req_ready, rsp_valid}, 3'b010);
    end
    @(posedge clk); #1 force_ack = 1'b0;

    waits = 0; run_req(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 8, 1'b0);
    waits = 2; run_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 16, 1'b0);
    waits = 0; run_req(32'h1234_5678, 32'h0000_0000, 64'h0, 8, 1'b0);
    waits = 0; run_req(32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 8, 1'b1);
    waits = 1; run_req(32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 12, 1'b0);
    waits = 0;

    // Responder never ACKs the C-low read.
    stall_adr = 17'h18;
    exp_bus(17'h10, 1'b1, 32'h7);
    exp_bus(17'h14, 1'b1, 32'h9);
`ifdef WB_MULT_TIMEOUT_EN
    exp_rsp(64'hBADFABAC_BADFABAC, 1'b1);
`endif
    handshake(32'h7, 32'h9);
    n = 0;
    while (!(stb && adr == 17'h18) && n < 30) begin @(negedge clk); n++; end
    check("stall_reached", {stb, adr}, {1'b1, 17'h18});
    n = 0;
    while (stb && n < 40) begin n++; @(negedge clk); end
`ifdef WB_MULT_TIMEOUT_EN
    check("timeout_stb_cycles", n, 7);
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("ready_after_timeout", req_ready, 1'b1);
`else
    check("stall_stb_held", n, 40);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_stall_rst", req_ready, 1'b1);
`endif
    stall_adr = 17'h1FFFF;

    // Reset pulse in the middle of the B write.
    waits = 3;
    exp_bus(17'h10, 1'b1, 32'h11);
    handshake(32'h11, 32'h22);
    n = 0;
    while (!(stb && adr == 17'h14) && n < 30) begin @(negedge clk); n++; end
    check("wr_b_reached", {stb, adr}, {1'b1, 17'h14});
    #2 rst_n = 1'b0;
    #1;
    check("midrst_bus", {cyc, stb, we}, 3'b000);
    check("midrst_ctrl", {rsp_valid, req_ready}, 2'b00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_midrst", req_ready, 1'b1);
    waits = 0;
    run_req(32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF, 8, 1'b0);

    repeat (3) @(negedge clk);
    check("bus_q_drained", bus_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
